// File: rtl/moonbase_bus_pkg.sv
// Shared bus encoding for the moonbase CPU and its board-side bridge.
// Bit positions of the multiplexed 8-bit bus and the 6-bit read return.
package moonbase_bus_pkg;

    localparam int unsigned STB    = 7;
    localparam int unsigned NIB    = 6;
    localparam int unsigned WRAM_N = 5;
    localparam int unsigned WDEV_N = 4;

    localparam int unsigned DATA_HI    = 3;
    localparam int unsigned DATA_LO    = 0;
    localparam int unsigned DATA_IN_HI = 5;
    localparam int unsigned DATA_IN_LO = 4;
    localparam int unsigned RAM_IN_HI  = 3;
    localparam int unsigned RAM_IN_LO  = 0;

    typedef enum logic [1:0] {
        CycAddrLo,
        CycAddrHi,
        CycData
    } bus_cycle_e;

    function automatic bus_cycle_e decode_cycle(input logic [7:0] bus);
        if (!bus[STB]) begin
            return CycData;
        end
        return bus[NIB] ? CycAddrHi : CycAddrLo;
    endfunction

endpackage

// File: rtl/moonbase_nibble_ram.sv
// Byte-organised RAM: asynchronous full-byte read, one synchronous write port
// with independent high/low nibble enables.
module moonbase_nibble_ram #(
    parameter int unsigned AW = 6
) (
    input  logic          clk,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic          we_hi,
    input  logic          we_lo,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we_hi) begin
            mem[waddr][7:4] <= wdata[7:4];
        end
        if (we_lo) begin
            mem[waddr][3:0] <= wdata[3:0];
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/moonbase_bus_bridge.sv
// Board-side bridge for the moonbase CPU: address latch, nibble RAM access,
// device register bank and host program-load port.
module moonbase_bus_bridge
    import moonbase_bus_pkg::*;
#(
    parameter int unsigned AW    = 6,
    parameter int unsigned N_DEV = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         cpu_bus,
    output logic [5:0]         cpu_rdata,
    input  logic [2*N_DEV-1:0] dev_in,
    output logic [8*N_DEV-1:0] dev_out,
    input  logic               load_en,
    input  logic [AW-1:0]      load_addr,
    input  logic [7:0]         load_data,
    output logic               load_collide,
    output logic [11:0]        addr_q
);

    localparam int unsigned DW = $clog2(N_DEV);

    bus_cycle_e  cycle;
    logic        nib;
    logic [3:0]  nibble;
    logic        cpu_ram_we;
    logic        cpu_dev_we;
    logic [11:0] addr_d;
    logic        collide_d;

    logic [AW-1:0] ram_idx;
    logic [DW-1:0] dev_idx;

    assign cycle   = decode_cycle(cpu_bus);
    assign nib     = cpu_bus[NIB];
    assign nibble  = cpu_bus[DATA_HI:DATA_LO];
    assign ram_idx = addr_q[AW-1:0];
    assign dev_idx = addr_q[DW-1:0];

    // The CPU is ignored entirely while held in reset.
    assign cpu_ram_we = !reset && (cycle == CycData) && !cpu_bus[WRAM_N];
    assign cpu_dev_we = !reset && (cycle == CycData) && !cpu_bus[WDEV_N];

    // Address latch
    always_comb begin
        addr_d = addr_q;
        unique case (cycle)
            CycAddrLo: addr_d[5:0]  = cpu_bus[5:0];
            CycAddrHi: addr_d[11:6] = cpu_bus[5:0];
            default:   addr_d       = addr_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    // RAM write arbitration: a host load owns the single write port.
    logic [AW-1:0] ram_waddr;
    logic [7:0]    ram_wdata;
    logic          ram_we_hi;
    logic          ram_we_lo;
    logic [7:0]    ram_rdata;

    always_comb begin
        ram_waddr = ram_idx;
        ram_wdata = {nibble, nibble};
        ram_we_hi = 1'b0;
        ram_we_lo = 1'b0;
        if (load_en) begin
            ram_waddr = load_addr;
            ram_wdata = load_data;
            ram_we_hi = 1'b1;
            ram_we_lo = 1'b1;
        end else if (cpu_ram_we) begin
            ram_we_hi = !nib;
            ram_we_lo = nib;
        end
    end

    assign collide_d = load_en && cpu_ram_we;

    always_ff @(posedge clk) begin
        if (reset) begin
            load_collide <= 1'b0;
        end else begin
            load_collide <= collide_d;
        end
    end

    moonbase_nibble_ram #(
        .AW (AW)
    ) u_ram (
        .clk   (clk),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .we_hi (ram_we_hi),
        .we_lo (ram_we_lo),
        .raddr (ram_idx),
        .rdata (ram_rdata)
    );

    // Device register bank
    logic [7:0] dev_q [N_DEV];
    logic [7:0] dev_d [N_DEV];

    always_comb begin
        dev_d = dev_q;
        if (cpu_dev_we) begin
            if (nib) begin
                dev_d[dev_idx][3:0] = nibble;
            end else begin
                dev_d[dev_idx][7:4] = nibble;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < int'(N_DEV); k++) begin
                dev_q[k] <= '0;
            end
        end else begin
            dev_q <= dev_d;
        end
    end

    for (genvar k = 0; k < int'(N_DEV); k++) begin : g_dev_out
        assign dev_out[8*k +: 8] = dev_q[k];
    end

    // Read return
    logic [1:0] data_in;
    logic [3:0] ram_in;

    always_comb begin
        data_in = 2'b00;
        for (int k = 0; k < int'(N_DEV); k++) begin
            if (dev_idx == k[DW-1:0]) begin
                data_in = dev_in[2*k +: 2];
            end
        end
    end

    assign ram_in = nib ? ram_rdata[3:0] : ram_rdata[7:4];

    assign cpu_rdata[DATA_IN_HI:DATA_IN_LO] = data_in;
    assign cpu_rdata[RAM_IN_HI:RAM_IN_LO]   = ram_in;

endmodule

// File: tb/tb_moonbase_bus_bridge.sv
// Randomised scoreboard bench for moonbase_bus_bridge against a byte-level
// reference model of the bridge.
module tb_moonbase_bus_bridge;

    localparam int AW    = 6;
    localparam int N_DEV = 4;
    localparam int RAM_N = 1 << AW;

    logic               clk;
    logic               reset;
    logic [7:0]         cpu_bus;
    logic [5:0]         cpu_rdata;
    logic [2*N_DEV-1:0] dev_in;
    logic [8*N_DEV-1:0] dev_out;
    logic               load_en;
    logic [AW-1:0]      load_addr;
    logic [7:0]         load_data;
    logic               load_collide;
    logic [11:0]        addr_q;

    moonbase_bus_bridge #(
        .AW    (AW),
        .N_DEV (N_DEV)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_bus      (cpu_bus),
        .cpu_rdata    (cpu_rdata),
        .dev_in       (dev_in),
        .dev_out      (dev_out),
        .load_en      (load_en),
        .load_addr    (load_addr),
        .load_data    (load_data),
        .load_collide (load_collide),
        .addr_q       (addr_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int         m_addr;
    logic [7:0] m_mem [RAM_N];
    logic [7:0] m_dev [N_DEV];
    logic       m_col;

    logic [5:0] exp_q [$];
    logic       rd_check = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] model_read(input logic nib, input logic [7:0] din);
        logic [7:0] b;
        int         pair;
        b    = m_mem[m_addr % RAM_N];
        pair = (int'(din) >> (2 * (m_addr % N_DEV))) & 3;
        return {pair[1:0], nib ? b[3:0] : b[7:4]};
    endfunction

    function automatic logic [31:0] model_dev_out();
        logic [31:0] v = '0;
        for (int k = 0; k < N_DEV; k++) begin
            v = v | (32'(m_dev[k]) << (8 * k));
        end
        return v;
    endfunction

    // Effect of one clock edge on the model.
    task automatic model_edge(input logic [7:0] bus, input logic len, input logic [5:0] la,
                              input logic [7:0] ld, input logic rst);
        int   ri;
        int   di;
        int   d;
        logic cpu_ram;
        ri = m_addr % RAM_N;
        di = m_addr % N_DEV;
        d  = int'(bus) & 15;
        cpu_ram = !rst && !bus[7] && !bus[5];
        if (rst) begin
            m_addr = 0;
            for (int k = 0; k < N_DEV; k++) m_dev[k] = 8'h00;
            m_col = 1'b0;
        end else begin
            m_col = len && cpu_ram;
            if (bus[7]) begin
                if (bus[6]) m_addr = (m_addr % 64) + (int'(bus) & 63) * 64;
                else        m_addr = (m_addr / 64) * 64 + (int'(bus) & 63);
            end else begin
                if (cpu_ram && !len) begin
                    if (bus[6]) m_mem[ri] = (m_mem[ri] & 8'hF0) | 8'(d);
                    else        m_mem[ri] = (m_mem[ri] & 8'h0F) | 8'(d << 4);
                end
                if (!bus[4]) begin
                    if (bus[6]) m_dev[di] = (m_dev[di] & 8'hF0) | 8'(d);
                    else        m_dev[di] = (m_dev[di] & 8'h0F) | 8'(d << 4);
                end
            end
        end
        if (len) m_mem[la] = ld;
    endtask

    task automatic step(input logic [7:0] bus, input logic len, input logic [5:0] la,
                        input logic [7:0] ld, input logic rst, input logic [7:0] din);
        cpu_bus   = bus;
        load_en   = len;
        load_addr = la;
        load_data = ld;
        reset     = rst;
        dev_in    = din;
        if (!rst && !bus[7]) begin
            exp_q.push_back(model_read(bus[6], din));
            rd_check = 1'b1;
        end else begin
            rd_check = 1'b0;
        end
        @(posedge clk);
        model_edge(bus, len, la, ld, rst);
        #1;
        chk("addr_q", 32'(addr_q), 32'(m_addr));
        chk("dev_out", dev_out, model_dev_out());
        chk("load_collide", 32'(load_collide), 32'(m_col));
    endtask

    task automatic cpu(input logic [7:0] bus);
        step(bus, 1'b0, '0, '0, 1'b0, dev_in);
    endtask

    // Monitor: compares the read return during every data cycle.
    always @(negedge clk) begin
        if (rd_check) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rdata: no expected value queued at %0t", $time);
            end else begin
                chk("rdata", 32'(cpu_rdata), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        m_addr = 0;
        m_col  = 1'b0;
        for (int k = 0; k < N_DEV; k++) m_dev[k] = 8'h00;
        dev_in = '0;

        // Preload every byte under reset while the bus toggles strobes.
        for (int a = 0; a < RAM_N; a++) begin
            step(8'($urandom) | 8'h80, 1'b1, 6'(a), 8'($urandom), 1'b1, 8'($urandom));
        end
        chk("reset addr_q", 32'(addr_q), 32'h0);
        chk("reset dev_out", dev_out, 32'h0);

        // Latch build
        step(8'h95, 1'b0, '0, '0, 1'b0, 8'h00);
        cpu(8'hC2);
        chk("latch 095", 32'(addr_q), 32'h095);
        cpu(8'h80);
        chk("latch 080", 32'(addr_q), 32'h080);

        // Byte store and read back at 0x005
        cpu(8'h85); cpu(8'hC0);
        cpu(8'h1A); cpu(8'h53);
        cpu(8'h30); cpu(8'h70);

        // Aliasing: store at 0x045, read at 0x005
        cpu(8'h85); cpu(8'hC1);
        cpu(8'h13); cpu(8'h5C);
        cpu(8'hC0);
        cpu(8'h30); cpu(8'h70);

        // Device path
        step(8'h82, 1'b0, '0, '0, 1'b0, 8'b10_01_11_00);
        cpu(8'hC0);
        cpu(8'h27); cpu(8'h69);
        chk("dev reg2", dev_out, 32'h0079_0000);
        cpu(8'h30);

        // Collision: CPU write to 0x07 dropped in favour of host load to 0x10
        cpu(8'h87);
        step(8'h1F, 1'b1, 6'h10, 8'hEE, 1'b0, dev_in);
        chk("collide pulse", 32'(load_collide), 32'h1);
        cpu(8'h30);
        chk("collide clear", 32'(load_collide), 32'h0);
        cpu(8'h70);
        cpu(8'h90); cpu(8'h30); cpu(8'h70);

        // Reset after low part only: high part then combines with zeros
        cpu(8'h95);
        step(8'h80, 1'b0, '0, '0, 1'b1, dev_in);
        cpu(8'hC2);
        chk("mid reset", 32'(addr_q), 32'h080);

        // Randomised traffic with occasional loads and resets
        for (int i = 0; i < 1500; i++) begin
            logic [7:0] bus;
            bus = 8'($urandom);
            if ($urandom_range(0, 3) == 0) bus[7] = 1'b1;
            step(bus, $urandom_range(0, 7) == 0, 6'($urandom), 8'($urandom),
                 $urandom_range(0, 99) == 0, 8'($urandom));
        end

        rd_check = 1'b0;
        @(posedge clk);
        chk("scoreboard drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
